// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
//   Registered 1-to-N stream demultiplexer with valid/ready flow control.
//   Every accepted word is steered by in_sel into one of CHANNELS holding
//   registers, or written to all of them when Broadcast is set. Each lane
//   drains on its own out_ready, so one stalled destination does not hold up
//   words aimed at the others. Idle lanes always present zero data.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   Enable      global accept enable (0 blocks new input, drain continues)
//   Broadcast   1 = accepted word is written to every lane
//   in_data     input word
//   in_sel      destination lane index
//   in_valid    input word present
//   in_ready    block accepts a word this cycle (combinational)
//   out_data    lane i data at bits [i*WIDTH +: WIDTH], zero when idle
//   out_valid   lane i holds a word
//   out_ready   downstream i consumes the held word
//   drop_count  saturating count of words discarded for an invalid select
//   sel_error   one-cycle pulse after a discarded word
// -----------------------------------------------------------------------------
module demux_stream #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      Enable,
    input  logic                      Broadcast,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [7:0]                drop_count,
    output logic                      sel_error
);

    // One bit wider than in_sel so the bound compares cleanly even when
    // CHANNELS is a power of two (every select is then legal).
    localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

    logic [CHANNELS-1:0] slot_free_s;
    logic [CHANNELS-1:0] load_s;
    logic [CHANNELS-1:0] valid_nxt_s;
    logic [CHANNELS-1:0] valid_r;
    logic [WIDTH-1:0]    data_nxt_s [CHANNELS];
    logic [WIDTH-1:0]    data_r     [CHANNELS];
    logic                sel_ok_s;
    logic                sel_free_s;
    logic                ready_s;
    logic                fire_s;
    logic                drop_s;
    logic [7:0]          drop_nxt_s;
    logic [7:0]          drop_r;
    logic                sel_error_r;

    // Slot availability and the accept decision; depends only on the select
    // controls and lane state, never on in_valid.
    always_comb begin
        slot_free_s = ~valid_r | out_ready;
        sel_ok_s    = ({1'b0, in_sel} < CH_LIM);
        sel_free_s  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_free_s = sel_free_s | ((in_sel == SEL_W'(i)) & slot_free_s[i]);
        end
        if (!Enable) begin
            ready_s = 1'b0;
        end else if (Broadcast) begin
            ready_s = &slot_free_s;
        end else if (sel_ok_s) begin
            ready_s = sel_free_s;
        end else begin
            // Out-of-range selects are always taken so they can be discarded.
            ready_s = 1'b1;
        end
        fire_s = in_valid & ready_s;
        drop_s = fire_s & ~Broadcast & ~sel_ok_s;
    end

    // Per-lane next state: a load wins over a same-cycle drain, which keeps
    // each lane at one word per cycle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            load_s[i] = fire_s & (Broadcast | (sel_ok_s & (in_sel == SEL_W'(i))));
            if (load_s[i]) begin
                valid_nxt_s[i] = 1'b1;
                data_nxt_s[i]  = in_data;
            end else if (valid_r[i] && out_ready[i]) begin
                valid_nxt_s[i] = 1'b0;
                data_nxt_s[i]  = {WIDTH{1'b0}};
            end else begin
                valid_nxt_s[i] = valid_r[i];
                data_nxt_s[i]  = data_r[i];
            end
        end
    end

    // Saturating discard counter next value.
    always_comb begin
        if (drop_s && (drop_r != 8'hFF)) begin
            drop_nxt_s = drop_r + 8'd1;
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // State registers for lanes, discard counter and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r     <= {CHANNELS{1'b0}};
            drop_r      <= 8'd0;
            sel_error_r <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            valid_r     <= valid_nxt_s;
            drop_r      <= drop_nxt_s;
            sel_error_r <= drop_s;
            for (int i = 0; i < CHANNELS; i++) begin
                data_r[i] <= data_nxt_s[i];
            end
        end
    end

    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_lane
        assign out_data[g*WIDTH +: WIDTH] = data_r[g];
    end

    assign in_ready   = ready_s;
    assign out_valid  = valid_r;
    assign drop_count = drop_r;
    assign sel_error  = sel_error_r;

endmodule

// File: tb/tb_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_stream
//   Directed bench: a 4-lane instance driven from a vector table, and a 3-lane
//   instance exercising out-of-range selects and counter saturation.
// -----------------------------------------------------------------------------
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        bcast;
    logic [3:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid4;
    logic        in_valid3;
    logic        in_ready4;
    logic        in_ready3;
    logic [15:0] out_data4;
    logic [11:0] out_data3;
    logic [3:0]  out_valid4;
    logic [2:0]  out_valid3;
    logic [3:0]  out_ready4;
    logic [2:0]  out_ready3;
    logic [7:0]  drop4;
    logic [7:0]  drop3;
    logic        serr4;
    logic        serr3;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(4), .CHANNELS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .Enable(en), .Broadcast(bcast),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid4),
        .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready4), .drop_count(drop4), .sel_error(serr4)
    );

    demux_stream #(.WIDTH(4), .CHANNELS(3)) u3 (
        .clk(clk), .rst_n(rst_n), .Enable(en), .Broadcast(bcast),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .drop_count(drop3), .sel_error(serr3)
    );

    typedef struct {
        logic        en;
        logic        bc;
        logic [3:0]  d;
        logic [1:0]  sel;
        logic        v;
        logic [3:0]  rdy;
        logic        exp_in_ready;
        logic [3:0]  exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          en    bc    d     sel   v     rdy      ir    valid    data
        vecs[0]  = '{1'b1, 1'b0, 4'hA, 2'd0, 1'b1, 4'b1111, 1'b1, 4'b0001, 16'h000A};
        vecs[1]  = '{1'b1, 1'b0, 4'hB, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b0010, 16'h00B0};
        vecs[2]  = '{1'b1, 1'b0, 4'hC, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 16'h0C00};
        vecs[3]  = '{1'b1, 1'b0, 4'hD, 2'd3, 1'b1, 4'b1111, 1'b1, 4'b1000, 16'hD000};
        vecs[4]  = '{1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h0000};
        // backpressure on lane 2, then load-over-drain
        vecs[5]  = '{1'b1, 1'b0, 4'h5, 2'd2, 1'b1, 4'b1011, 1'b1, 4'b0100, 16'h0500};
        vecs[6]  = '{1'b1, 1'b0, 4'h6, 2'd2, 1'b1, 4'b1011, 1'b0, 4'b0100, 16'h0500};
        vecs[7]  = '{1'b1, 1'b0, 4'h6, 2'd2, 1'b1, 4'b1111, 1'b1, 4'b0100, 16'h0600};
        vecs[8]  = '{1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h0000};
        // broadcast blocked by stalled lane 1
        vecs[9]  = '{1'b1, 1'b0, 4'h3, 2'd1, 1'b1, 4'b1101, 1'b1, 4'b0010, 16'h0030};
        vecs[10] = '{1'b1, 1'b1, 4'h9, 2'd1, 1'b1, 4'b1101, 1'b0, 4'b0010, 16'h0030};
        vecs[11] = '{1'b1, 1'b1, 4'h9, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b1111, 16'h9999};
        vecs[12] = '{1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h0000};
        // Enable low blocks input while lane 0 still drains
        vecs[13] = '{1'b1, 1'b0, 4'h7, 2'd0, 1'b1, 4'b1110, 1'b1, 4'b0001, 16'h0007};
        vecs[14] = '{1'b0, 1'b0, 4'h8, 2'd1, 1'b1, 4'b1110, 1'b0, 4'b0001, 16'h0007};
        vecs[15] = '{1'b0, 1'b0, 4'h8, 2'd1, 1'b1, 4'b1111, 1'b0, 4'b0000, 16'h0000};
        vecs[16] = '{1'b1, 1'b0, 4'h8, 2'd1, 1'b1, 4'b1111, 1'b1, 4'b0010, 16'h0080};

        rst_n      = 1'b0;
        en         = 1'b1;
        bcast      = 1'b0;
        in_data    = 4'h0;
        in_sel     = 2'd0;
        in_valid4  = 1'b0;
        in_valid3  = 1'b0;
        out_ready4 = 4'b1111;
        out_ready3 = 3'b111;
        #2;
        check("rst_valid4", 32'(out_valid4), 32'h0);
        check("rst_data4",  32'(out_data4),  32'h0);
        check("rst_drop4",  32'(drop4),      32'h0);
        check("rst_ready4", 32'(in_ready4),  32'h1);
        check("rst_valid3", 32'(out_valid3), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven 4-lane vectors
        for (int i = 0; i < 17; i++) begin
            en         = vecs[i].en;
            bcast      = vecs[i].bc;
            in_data    = vecs[i].d;
            in_sel     = vecs[i].sel;
            in_valid4  = vecs[i].v;
            out_ready4 = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready4), 32'(vecs[i].exp_in_ready));
            tick();
            check($sformatf("v%0d_valid", i), 32'(out_valid4), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_data", i),  32'(out_data4),  32'(vecs[i].exp_data));
        end

        // Lane 1 holds 0x8; asynchronous reset between edges clears it at once
        in_valid4  = 1'b0;
        out_ready4 = 4'b0000;
        en         = 1'b1;
        bcast      = 1'b0;
        tick();
        check("hold_valid", 32'(out_valid4), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid4), 32'h0);
        check("arst_data",  32'(out_data4),  32'h0);
        check("arst_ready", 32'(in_ready4),  32'h1);
        #1;
        rst_n      = 1'b1;
        out_ready4 = 4'b1111;
        tick();

        // 3-lane instance: legal unicast to the top lane
        in_valid3 = 1'b1;
        in_sel    = 2'd2;
        in_data   = 4'hE;
        #1;
        check("c3_ready_sel2", 32'(in_ready3), 32'h1);
        tick();
        check("c3_valid_sel2", 32'(out_valid3), 32'h4);
        check("c3_data_sel2",  32'(out_data3),  32'hE00);

        // Three discards on select 3
        in_sel = 2'd3;
        for (int k = 0; k < 3; k++) begin
            in_data = 4'(k + 1);
            #1;
            check($sformatf("c3_ready_bad%0d", k), 32'(in_ready3), 32'h1);
            tick();
            check($sformatf("c3_serr_bad%0d", k),  32'(serr3),      32'h1);
            check($sformatf("c3_valid_bad%0d", k), 32'(out_valid3), 32'h0);
        end
        in_valid3 = 1'b0;
        tick();
        check("c3_serr_clear", 32'(serr3), 32'h0);
        check("c3_drop3",      32'(drop3), 32'd3);

        // Drive the counter to saturation, then one more discard
        in_valid3 = 1'b1;
        for (int k = 0; k < 252; k++) begin
            tick();
        end
        in_valid3 = 1'b0;
        tick();
        check("c3_drop255", 32'(drop3), 32'd255);
        in_valid3 = 1'b1;
        tick();
        check("c3_serr_sat", 32'(serr3), 32'h1);
        in_valid3 = 1'b0;
        tick();
        check("c3_drop_sat", 32'(drop3), 32'd255);
        check("c4_drop_idle", 32'(drop4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
